// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: HD44780 read-side engine (busy flag / address counter and
// DDRAM/CGRAM data reads) with optional busy-flag polling.
// Optional poll timeout is enabled by defining LCD_POLL_TIMEOUT_EN; the
// TIMEOUT_CYC parameter exists only in that build.
module lcd_bus_reader #(
  parameter int T_AS  = 1,
  parameter int T_PW  = 4,
  parameter int T_REC = 3
`ifdef LCD_POLL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 18215
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_rs,
  input  logic       i_poll,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_bf,
  output logic [6:0] o_ac,
  output logic       o_timeout,
  output logic       o_bus_own,
  input  logic [7:0] i_lcd_data,
  output logic       o_lcd_en,
  output logic       o_lcd_rw,
  output logic       o_lcd_rs
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HIGH,
    S_EN_LOW,
    S_DONE
  } state_t;

  localparam int PH_MAX = (T_AS > T_PW) ? ((T_AS > T_REC) ? T_AS : T_REC)
                                        : ((T_PW > T_REC) ? T_PW : T_REC);
  localparam int CW = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

  localparam logic [CW-1:0] AS_LD  = CW'(T_AS - 1);
  localparam logic [CW-1:0] PW_LD  = CW'(T_PW - 1);
  localparam logic [CW-1:0] REC_LD = CW'(T_REC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic          poll_q, poll_d;
  logic [7:0]    data_q, data_d;

`ifdef LCD_POLL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYC);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Next-state, phase down-counter and sample/latch logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    poll_d  = poll_q;
    data_d  = data_q;
`ifdef LCD_POLL_TIMEOUT_EN
    timeout_d = timeout_q;
    tcnt_d    = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_req) begin
          rs_d    = i_rs;
          poll_d  = i_poll & ~i_rs;
          cnt_d   = AS_LD;
          state_d = S_SETUP;
`ifdef LCD_POLL_TIMEOUT_EN
          timeout_d = 1'b0;
          tcnt_d    = '0;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = PW_LD;
          state_d = S_EN_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EN_HIGH: begin
        if (cnt_q == '0) begin
          data_d  = i_lcd_data;
          cnt_d   = REC_LD;
          state_d = S_EN_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EN_LOW: begin
        if (cnt_q == '0) begin
          if (poll_q && data_q[7]) begin
`ifdef LCD_POLL_TIMEOUT_EN
            // Limit is checked only here so an EN pulse is never cut short.
            if (tcnt_q >= T_LIMIT) begin
              timeout_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              cnt_d   = AS_LD;
              state_d = S_SETUP;
            end
`else
            cnt_d   = AS_LD;
            state_d = S_SETUP;
`endif
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      poll_q  <= 1'b0;
      data_q  <= '0;
`ifdef LCD_POLL_TIMEOUT_EN
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      poll_q  <= poll_d;
      data_q  <= data_d;
`ifdef LCD_POLL_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    o_ready   = (state_q == S_IDLE);
    o_valid   = (state_q == S_DONE);
    o_bus_own = (state_q != S_IDLE);
    o_lcd_en  = (state_q == S_EN_HIGH);
    o_lcd_rw  = (state_q != S_IDLE);
    o_lcd_rs  = rs_q & (state_q != S_IDLE);
    o_data    = data_q;
    o_bf      = data_q[7];
    o_ac      = data_q[6:0];
`ifdef LCD_POLL_TIMEOUT_EN
    o_timeout = timeout_q;
`else
    o_timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: scoreboard bench for lcd_bus_reader. Stimulus pushes
// expected read results; a monitor thread pops and compares on o_valid.
// Define LCD_POLL_TIMEOUT_EN to exercise the poll timeout build.
module tb_lcd_bus_reader;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_req = 1'b0;
  logic       i_rs = 1'b0;
  logic       i_poll = 1'b0;
  logic       o_ready, o_valid, o_bf, o_timeout, o_bus_own;
  logic [7:0] o_data;
  logic [6:0] o_ac;
  logic [7:0] i_lcd_data = 8'h00;
  logic       o_lcd_en, o_lcd_rw, o_lcd_rs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // LCD model: first busy_n EN pulses of a read return BF=1, then fin_byte
  int         en_pulses = 0;
  int         en_base = 0;
  int         busy_n = 0;
  logic [7:0] fin_byte = 8'h00;
  logic       en_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

`ifdef LCD_POLL_TIMEOUT_EN
  lcd_bus_reader #(.T_AS(1), .T_PW(4), .T_REC(3), .TIMEOUT_CYC(100)) dut (
`else
  lcd_bus_reader #(.T_AS(1), .T_PW(4), .T_REC(3)) dut (
`endif
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_rs(i_rs), .i_poll(i_poll),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_bf(o_bf),
    .o_ac(o_ac), .o_timeout(o_timeout), .o_bus_own(o_bus_own),
    .i_lcd_data(i_lcd_data), .o_lcd_en(o_lcd_en), .o_lcd_rw(o_lcd_rw),
    .o_lcd_rs(o_lcd_rs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (o_lcd_en && !en_prev) en_pulses = en_pulses + 1;
    en_prev = o_lcd_en;
    i_lcd_data = ((en_pulses - en_base) <= busy_n) ? 8'h80 : fin_byte;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one read; returns at the negedge of the cycle after accept
  task automatic issue(input logic rs, input logic poll, input int busy,
                       input logic [7:0] fin, input bit push, input logic [7:0] edata,
                       input logic eto, input int lat);
    exp_t e;
    @(negedge clk);
    busy_n   = busy;
    fin_byte = fin;
    en_base  = en_pulses;
    chk("ready_at_accept", {31'd0, o_ready}, 32'd1);
    i_req  = 1'b1;
    i_rs   = rs;
    i_poll = poll;
    if (push) begin
      e.data = edata;
      e.to   = eto;
      e.cyc  = cyc + lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  task automatic watch_single(input logic rs);
    for (int rel = 1; rel <= 9; rel++) begin
      chk("en_phase", {31'd0, o_lcd_en}, {31'd0, (rel >= 2 && rel <= 5)});
      chk("rw_phase", {31'd0, o_lcd_rw}, 32'd1);
      chk("rs_phase", {31'd0, o_lcd_rs}, {31'd0, rs});
      chk("own_phase", {31'd0, o_bus_own}, 32'd1);
      if (rel < 9) @(negedge clk);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("o_data", {24'd0, o_data}, {24'd0, e.data});
            chk("o_bf", {31'd0, o_bf}, {31'd0, e.data[7]});
            chk("o_ac", {25'd0, o_ac}, {25'd0, e.data[6:0]});
            chk("o_timeout", {31'd0, o_timeout}, {31'd0, e.to});
            chk("ready_in_done", {31'd0, o_ready}, 32'd0);
          end
        end
      end
    join_none

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_en_rw_rs", {29'd0, o_lcd_en, o_lcd_rw, o_lcd_rs}, 32'd0);
    chk("rst_bus_own", {31'd0, o_bus_own}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
    i_rst = 1'b0;

    // BF/AC instruction read
    issue(1'b0, 1'b0, 0, 8'h25, 1'b1, 8'h25, 1'b0, 9);
    watch_single(1'b0);
    drain(20);
    chk("bf_read_pulses", en_pulses - en_base, 32'd1);

    // Data read, issued straight after the previous one finished
    issue(1'b1, 1'b0, 0, 8'h52, 1'b1, 8'h52, 1'b0, 9);
    watch_single(1'b1);
    drain(20);

    // Data read with poll set: poll ignored, one pulse even with bit 7 high
    issue(1'b1, 1'b1, 5, 8'h52, 1'b1, 8'h80, 1'b0, 9);
    drain(20);
    chk("rs_poll_pulses", en_pulses - en_base, 32'd1);

    // BF poll: three busy reads then 8'h05
    issue(1'b0, 1'b1, 3, 8'h05, 1'b1, 8'h05, 1'b0, 33);
    drain(60);
    chk("poll_pulses", en_pulses - en_base, 32'd4);

    // Request during a read is ignored
    issue(1'b0, 1'b0, 0, 8'h3c, 1'b1, 8'h3c, 1'b0, 9);
    repeat (3) @(negedge clk);
    i_req = 1'b1;
    i_rs  = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    drain(20);
    repeat (12) @(negedge clk);
    chk("ignored_req_pulses", en_pulses - en_base, 32'd1);
    chk("ignored_req_idle", {31'd0, o_bus_own}, 32'd0);

    // Reset during EN_HIGH
    issue(1'b0, 1'b0, 0, 8'h11, 1'b0, 8'h00, 1'b0, 0);
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("midrst_en", {31'd0, o_lcd_en}, 32'd0);
    chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    chk("midrst_data", {24'd0, o_data}, 32'd0);
    i_rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_pulses", en_pulses - en_base, 32'd1);
    chk("midrst_idle", {31'd0, o_ready}, 32'd1);

`ifdef LCD_POLL_TIMEOUT_EN
    // BF stuck high: timeout after 13 reads
    issue(1'b0, 1'b1, 100000, 8'h00, 1'b1, 8'h80, 1'b1, 105);
    drain(200);
    chk("timeout_pulses", en_pulses - en_base, 32'd13);
    issue(1'b0, 1'b0, 0, 8'h07, 1'b1, 8'h07, 1'b0, 9);
    drain(20);
`else
    // BF stuck high: polls indefinitely
    issue(1'b0, 1'b1, 100000, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    repeat (1000) @(negedge clk);
    chk("stuck_bus_own", {31'd0, o_bus_own}, 32'd1);
    chk("stuck_timeout", {31'd0, o_timeout}, 32'd0);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    chk("stuck_rst_ready", {31'd0, o_ready}, 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
